// File: rtl/lock_pkg.sv
// Shared definitions for the keypad front end and digital_lock.
// Holds the FSM state type, the key code constants, the digit width and
// the (row, col) to key code map of the 4x4 keypad.
package lock_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      EMIT,
      WAIT_RELEASE
   } kp_state_t;

   localparam logic [DIGIT_W-1:0] KEY_STAR = 4'hE;
   localparam logic [DIGIT_W-1:0] KEY_HASH = 4'hF;
   // Letter keys A-D all collapse to one code that is never emitted.
   localparam logic [DIGIT_W-1:0] KEY_NONE = 4'hA;

   function automatic logic [DIGIT_W-1:0] keymap(input logic [1:0] row,
                                                 input logic [1:0] col);
      logic [DIGIT_W-1:0] code;
      code = KEY_NONE;
      case ({row, col})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = 4'd0;
         4'b11_10: code = KEY_HASH;
         default:  code = KEY_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high (rows read as released)
//   row_in    raw keypad rows, active-low
//   row_sync  synchronised rows
module keypad_row_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] row_sync
);

   logic [3:0] row_meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= 4'b1111;
         row_sync <= 4'b1111;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end for digital_lock: scans a 4x4 active-low matrix,
// debounces press and release, and turns each key into a single-cycle
// digit / submit / clear / reject pulse.
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   row_in[3:0]      keypad rows, active-low, asynchronous
//   col_out[3:0]     keypad column drive, active-low, at most one low
//   ready_for_input  lock accepts keys only while high
//   digit_valid      one-cycle pulse, digit_in valid in that cycle
//   digit_in[3:0]    last accepted digit, held
//   submit           one-cycle pulse on '#'
//   clear            one-cycle pulse on '*'
//   key_reject       one-cycle pulse when a key is dropped
//   digit_cnt        digits accepted in the current entry
//
// state        | meaning
// SCAN         | drive column col for SCAN_DIV cycles, sample rows in last
// DEBOUNCE     | hold column, require latched row pattern DEBOUNCE_CNT cycles
// EMIT         | one cycle, decide which pulse to register
// WAIT_RELEASE | hold column, require all rows high DEBOUNCE_CNT cycles
module keypad_entry
   import lock_pkg::*;
#(
   parameter int CODE_LEN     = 4,
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 1000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [3:0]                       row_in,
   output logic [3:0]                       col_out,
   input  logic                             ready_for_input,
   output logic                             digit_valid,
   output logic [DIGIT_W-1:0]               digit_in,
   output logic                             submit,
   output logic                             clear,
   output logic                             key_reject,
   output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt
);

   localparam int CNT_W  = $clog2(CODE_LEN+1);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

   localparam logic [SCAN_W-1:0] SCAN_LOAD = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CNT - 1);

   logic [3:0]         rs;
   kp_state_t          state;
   logic [1:0]         col;
   logic               active;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [DEB_W-1:0]   deb_cnt;
   logic [3:0]         key_rows;
   logic [DIGIT_W-1:0] key_code;

   logic               one_low;
   logic [1:0]         row_idx;

   keypad_row_sync u_row_sync (
      .clk      (clk),
      .rst      (rst),
      .row_in   (row_in),
      .row_sync (rs)
   );

   // Columns stay undriven until the first cycle out of reset.
   assign col_out = active ? ~(4'b0001 << col) : 4'b1111;

   // Exactly one row low is a valid press; anything else (none, or ghosting) is skipped.
   always_comb begin
      one_low = 1'b0;
      row_idx = 2'd0;
      case (rs)
         4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
         4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
         4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
         4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
         default: begin one_low = 1'b0; row_idx = 2'd0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SCAN;
         col         <= 2'd0;
         active      <= 1'b0;
         scan_cnt    <= SCAN_LOAD;
         deb_cnt     <= DEB_LOAD;
         key_rows    <= 4'b1111;
         key_code    <= KEY_NONE;
         digit_valid <= 1'b0;
         digit_in    <= '0;
         submit      <= 1'b0;
         clear       <= 1'b0;
         key_reject  <= 1'b0;
         digit_cnt   <= '0;
      end else begin
         digit_valid <= 1'b0;
         submit      <= 1'b0;
         clear       <= 1'b0;
         key_reject  <= 1'b0;
         active      <= 1'b1;

         case (state)
            SCAN: begin
               // First cycle out of reset only turns the column on.
               if (active) begin
                  if (scan_cnt != '0) begin
                     scan_cnt <= scan_cnt - 1'b1;
                  end else if (one_low) begin
                     key_rows <= rs;
                     key_code <= keymap(row_idx, col);
                     deb_cnt  <= DEB_LOAD;
                     state    <= DEBOUNCE;
                  end else begin
                     col      <= col + 2'd1;
                     scan_cnt <= SCAN_LOAD;
                  end
               end
            end

            DEBOUNCE: begin
               if (rs != key_rows) begin
                  col      <= col + 2'd1;
                  scan_cnt <= SCAN_LOAD;
                  state    <= SCAN;
               end else if (deb_cnt == '0) begin
                  state <= EMIT;
               end else begin
                  deb_cnt <= deb_cnt - 1'b1;
               end
            end

            EMIT: begin
               if (key_code != KEY_NONE) begin
                  if (!ready_for_input) begin
                     key_reject <= 1'b1;
                  end else if (key_code == KEY_HASH) begin
                     submit    <= 1'b1;
                     digit_cnt <= '0;
                  end else if (key_code == KEY_STAR) begin
                     clear     <= 1'b1;
                     digit_cnt <= '0;
                  end else if (digit_cnt == CNT_W'(CODE_LEN)) begin
                     key_reject <= 1'b1;
                  end else begin
                     digit_valid <= 1'b1;
                     digit_in    <= key_code;
                     digit_cnt   <= digit_cnt + 1'b1;
                  end
               end
               deb_cnt <= DEB_LOAD;
               state   <= WAIT_RELEASE;
            end

            WAIT_RELEASE: begin
               if (rs != 4'b1111) begin
                  deb_cnt <= DEB_LOAD;
               end else if (deb_cnt == '0) begin
                  col      <= col + 2'd1;
                  scan_cnt <= SCAN_LOAD;
                  state    <= SCAN;
               end else begin
                  deb_cnt <= deb_cnt - 1'b1;
               end
            end

            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 keypad model.
module tb_keypad_entry;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       ready_for_input = 1'b1;
   logic       digit_valid;
   logic [3:0] digit_in;
   logic       submit;
   logic       clear;
   logic       key_reject;
   logic [2:0] digit_cnt;

   logic [3:0][3:0] press = '0;   // press[row][col]
   logic            tog_low = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   int n_dv = 0, n_sub = 0, n_clr = 0, n_rej = 0, n_viol = 0;
   int dlog[$];
   bit prev_pulse = 1'b0;

   always #5 clk = ~clk;

   keypad_entry #(.CODE_LEN(4), .SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .row_in          (row_in),
      .col_out         (col_out),
      .ready_for_input (ready_for_input),
      .digit_valid     (digit_valid),
      .digit_in        (digit_in),
      .submit          (submit),
      .clear           (clear),
      .key_reject      (key_reject),
      .digit_cnt       (digit_cnt)
   );

   always_comb begin
      row_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[r][c] && !col_out[c]) row_in[r] = 1'b0;
      if (tog_low && !col_out[1]) row_in[1] = 1'b0;
   end

   // Pulse monitor: counts every pulse and flags overlap / back-to-back pulses.
   always @(negedge clk) begin
      int np;
      if (!rst) begin
         np = int'(digit_valid) + int'(submit) + int'(clear) + int'(key_reject);
         if (np > 1) n_viol++;
         if (np != 0 && prev_pulse) n_viol++;
         if (digit_cnt > 3'd4) n_viol++;
         prev_pulse = (np != 0);
         if (digit_valid) begin n_dv++; dlog.push_back(int'(digit_in)); end
         if (submit)      n_sub++;
         if (clear)       n_clr++;
         if (key_reject)  n_rej++;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves rst low; the next posedge is the first cycle out of reset.
   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
   endtask

   task automatic press_key(input int r, input int c);
      press[r][c] = 1'b1;
      tick(60);
      press[r][c] = 1'b0;
      tick(40);
   endtask

   task automatic check_digits(input string tag, input int base, input int a,
                               input int b, input int c, input int d);
      int exp[4];
      exp = '{a, b, c, d};
      for (int i = 0; i < 4; i++)
         check(tag, (base + i < dlog.size()) ? dlog[base + i] : -1, exp[i]);
   endtask

   initial begin
      int first, b_dv, b_sub, b_clr, b_rej, base;
      bit [3:0] seen;

      // Reset state
      rst = 1'b1;
      tick(3);
      check("rst_col_out", int'(col_out), 15);
      check("rst_outputs", int'({digit_valid, submit, clear, key_reject}), 0);
      check("rst_digit_cnt", int'(digit_cnt), 0);

      // 1: single key '1', latency and no repeat
      press[0][0] = 1'b1;
      rst = 1'b0;
      b_dv = n_dv;
      first = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 1) check("t1_col0_first", int'(col_out), 4'b1110);
         if (digit_valid && first == 0) first = k;
      end
      check("t1_latency", first, 14);
      check("t1_digit_in", int'(digit_in), 1);
      check("t1_cnt", int'(digit_cnt), 1);
      press[0][0] = 1'b0;
      tick(40);
      check("t1_one_pulse", n_dv - b_dv, 1);

      // 2: 1,2,3,4 then '#'
      do_reset();
      b_dv = n_dv; b_sub = n_sub; base = dlog.size();
      press_key(0, 0); press_key(0, 1); press_key(0, 2); press_key(1, 0);
      check("t2_dv_count", n_dv - b_dv, 4);
      check_digits("t2_digits", base, 1, 2, 3, 4);
      check("t2_cnt4", int'(digit_cnt), 4);
      press_key(3, 2);
      check("t2_submit", n_sub - b_sub, 1);
      check("t2_cnt0", int'(digit_cnt), 0);

      // 3: bouncing row 1 on column 1
      do_reset();
      b_dv = n_dv; b_sub = n_sub; b_clr = n_clr; b_rej = n_rej;
      for (int k = 0; k < 40; k++) begin
         if (k % 3 == 0) tog_low = ~tog_low;
         tick();
      end
      tog_low = 1'b0;
      tick(30);
      check("t3_no_pulse", (n_dv - b_dv) + (n_sub - b_sub) + (n_clr - b_clr), 0);
      check("t3_no_reject", n_rej - b_rej, 0);
      seen = '0;
      for (int k = 0; k < 20; k++) begin
         for (int c = 0; c < 4; c++) if (col_out == ~(4'b0001 << c)) seen[c] = 1'b1;
         tick();
      end
      check("t3_scan_all_cols", int'(seen), 15);

      // 4: 5,6,7,8,9 (overflow) then '*'
      do_reset();
      b_dv = n_dv; b_rej = n_rej; b_clr = n_clr; base = dlog.size();
      press_key(1, 1); press_key(1, 2); press_key(2, 0); press_key(2, 1); press_key(2, 2);
      check("t4_dv_count", n_dv - b_dv, 4);
      check_digits("t4_digits", base, 5, 6, 7, 8);
      check("t4_reject", n_rej - b_rej, 1);
      check("t4_cnt4", int'(digit_cnt), 4);
      check("t4_digit_in_held", int'(digit_in), 8);
      press_key(3, 0);
      check("t4_clear", n_clr - b_clr, 1);
      check("t4_cnt0", int'(digit_cnt), 0);

      // 5: not ready, then letter key
      do_reset();
      press_key(0, 2);
      check("t5_pre_digit", int'(digit_in), 3);
      ready_for_input = 1'b0;
      b_dv = n_dv; b_rej = n_rej; b_sub = n_sub; b_clr = n_clr;
      press_key(2, 0);
      check("t5_reject", n_rej - b_rej, 1);
      check("t5_no_dv", n_dv - b_dv, 0);
      check("t5_digit_in", int'(digit_in), 3);
      check("t5_cnt", int'(digit_cnt), 1);
      ready_for_input = 1'b1;
      b_rej = n_rej;
      press_key(0, 3);
      check("t5_letter_silent",
            (n_dv - b_dv) + (n_rej - b_rej) + (n_sub - b_sub) + (n_clr - b_clr), 0);

      // 6a: ghosting on column 0
      press[0][0] = 1'b1;
      press[1][0] = 1'b1;
      do_reset();
      b_dv = n_dv; b_rej = n_rej;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 5) check("t6_ghost_advance", int'(col_out), 4'b1101);
      end
      press[0][0] = 1'b0;
      press[1][0] = 1'b0;
      tick(20);
      check("t6_ghost_silent", (n_dv - b_dv) + (n_rej - b_rej), 0);

      // 6b: reset during debounce of '2'
      press[0][1] = 1'b1;
      do_reset();
      b_dv = n_dv;
      tick(11);
      rst = 1'b1;
      tick();
      check("t6_rst_col", int'(col_out), 15);
      check("t6_rst_outs", int'({digit_valid, submit, clear, key_reject, digit_in, digit_cnt}), 0);
      press[0][1] = 1'b0;
      tick(2);
      rst = 1'b0;
      tick();
      check("t6_col0_first", int'(col_out), 4'b1110);
      tick(60);
      check("t6_no_pulse", n_dv - b_dv, 0);

      check("pulse_rules", n_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Front end that produces the digit/submit entry interface consumed by digital_lock.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the rows, and maps each key to a code.
- Emits single-cycle digit_valid/digit_in, submit and clear pulses, gated by the lock's ready_for_input.
- Sits between board keypad pins and digital_lock.

Parameters:
- CODE_LEN, 4: maximum digits accepted per entry; must match digital_lock.
- SCAN_DIV, 16: clock cycles each column is driven; minimum 4.
- DEBOUNCE_CNT, 1000: consecutive stable cycles required to accept a press and to accept a release; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- row_in  in  4  keypad rows, active-low, asynchronous.
- col_out  out  4  keypad column drive, active-low, at most one bit low.
- ready_for_input  in  1  from digital_lock; keys are accepted only while high.
- digit_valid  out  1  one-cycle pulse; digit_in is valid in that cycle.
- digit_in  out  4  digit 0-9, held until the next digit.
- submit  out  1  one-cycle pulse on '#'.
- clear  out  1  one-cycle pulse on '*'.
- key_reject  out  1  one-cycle pulse when a key is dropped.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits accepted in the current entry.

Behaviour:
- Reset (rst high at a clk edge) overrides everything:
  - col_out=4'b1111; all pulses, digit_in and digit_cnt = 0.
  - State SCAN, column index 0.
  - This also applies mid-debounce and mid-emit: no pulse is issued after reset.
  - col_out[0] goes low in the first cycle after reset deasserts.
- row_in passes through a 2-FF synchroniser; all logic uses the synchronised rows (rs).
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - A-D are ignored: no pulse, no reject.
- State SCAN:
  - Drive column c low for SCAN_DIV cycles; sample rs in the last cycle of the period.
  - Exactly one row low: latch (r,c), go to DEBOUNCE.
  - No row low, or more than one row low (ghosting): advance c, wrapping 3 to 0.
- State DEBOUNCE:
  - Hold column c. Count cycles while rs equals the latched pattern.
  - Any mismatch: back to SCAN at column c+1.
  - Count reaches DEBOUNCE_CNT: go to EMIT.
- State EMIT (one cycle), registered outputs:
  - Pulse asserts in the cycle after EMIT, i.e. sample cycle + DEBOUNCE_CNT + 2.
  - ready_for_input low: key_reject for any mapped key.
  - Digit with digit_cnt==CODE_LEN: key_reject; digit_cnt unchanged.
  - Digit otherwise: digit_valid, digit_in=value, digit_cnt+1.
  - '#': submit, digit_cnt=0. Submit is sent even with fewer than CODE_LEN digits; the lock judges it.
  - '*': clear, digit_cnt=0.
  - Then go to WAIT_RELEASE.
- State WAIT_RELEASE:
  - Hold column c; require rs==4'b1111 for DEBOUNCE_CNT consecutive cycles, then SCAN at column c+1.
  - A held key never repeats.
  - A second key pressed while the first is held is ignored.
- At most one output pulse per cycle; pulses are never back-to-back.
- Counters saturate, never wrap; digit_cnt never exceeds CODE_LEN.

Decomposition:
- Shared package lock_pkg holds:
  - state enum (SCAN, DEBOUNCE, EMIT, WAIT_RELEASE)
  - key code constants: KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_NONE (A-D)
  - keymap function from (row,col) to code
  - DIGIT_W=4
- One sub-module: keypad_row_sync, the 2-FF synchroniser for row_in.
- Scan FSM, debounce counter and emit logic stay in keypad_entry.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8, CODE_LEN=4, ready_for_input=1 unless stated.
1. Hold row0 low while col_out=4'b1110 for 60 cycles, then release -> exactly one digit_valid with digit_in=1, digit_cnt=1; pulse lands sample cycle +10; no repeat while held.
2. Press keys 1,2,3,4, then '#' -> four digit_valid pulses (1,2,3,4), digit_cnt reaches 4, then one submit pulse and digit_cnt=0.
3. Row1 toggles every 3 cycles for 40 cycles during col1, then released -> no pulses, no key_reject; scanning continues.
4. Keys 5,6,7,8,9 -> four digit_valid and one key_reject, digit_cnt=4; then '*' -> clear pulse, digit_cnt=0.
5. ready_for_input=0, press '7' -> key_reject only; digit_in and digit_cnt unchanged. Press 'A' -> no output at all.
6. Rows 0 and 1 low together on col0 -> ignored, scan advances to col1. Separately, assert rst during DEBOUNCE of key '2' -> next cycle col_out=4'b1111 and all outputs 0; after release, col0 is driven first and no '2' pulse appears.
